// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vpu_pkg
// Purpose : Shared constants and types for the vector core's result-matrix
//           readout path. A matrix word is ROWS x COLS elements of ELEM_W
//           bits, stored row-major with element (0,0) in the top byte.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package vpu_pkg;

  localparam int ELEM_W   = 8;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int NUM_ELEM = ROWS * COLS;
  localparam int DATA_W   = NUM_ELEM * ELEM_W;
  localparam int ADDR_W   = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } readout_state_t;

endpackage : vpu_pkg
`default_nettype wire

// File: rtl/byte_shift_out.sv
`default_nettype none
// ============================================================================
// Module  : byte_shift_out
// Purpose : Matrix-word load/shift register with element counter. The top
//           byte is always the element currently on offer; each shift moves
//           the next element up and advances the row/col counter.
// Ports   : clk, rst (async active-low)
//           load_i   - load data_i, clear counter
//           shift_i  - shift left one element, count up
//           data_i   - full matrix word
//           byte_o   - current element (top byte)
//           count_o  - index of current element (row = [3:2], col = [1:0])
// Rev     : 1.0  initial release
// ============================================================================
module byte_shift_out
  import vpu_pkg::*;
#(
  parameter int WORD_W = vpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [ELEM_W-1:0] byte_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[WORD_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
      // Natural 4-bit wrap: 15 -> 0 happens exactly on the final element.
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_o  = shift_q[WORD_W-1 -: ELEM_W];
  assign count_o = cnt_q;

endmodule : byte_shift_out
`default_nettype wire

// File: rtl/matrix_readout_unit.sv
`default_nettype none
// ============================================================================
// Module  : matrix_readout_unit
// Purpose : Reads a committed 128-bit result matrix back from MemData port b
//           and streams it out row-major as 16 bytes over valid/ready.
// Ports   : clk, rst (async active-low)
//           start, start_addr         - trigger (memWrite strobe) and address
//           mem_addr, mem_rden, mem_q - MemData port-b read interface
//           byte_data/valid/ready     - element stream
//           byte_row, byte_col        - position of byte_data in the matrix
//           byte_last                 - marks element (3,3)
//           busy, done, overrun       - status
// Rev     : 1.0  initial release
// ============================================================================
module matrix_readout_unit #(
  parameter int DATA_W       = vpu_pkg::DATA_W,
  parameter int ADDR_W       = vpu_pkg::ADDR_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [1:0]        byte_row,
  output logic [1:0]        byte_col,
  output logic              byte_last,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  import vpu_pkg::*;

  // WAIT lasts READ_LATENCY cycles; the latency counter runs 0..LAT_LAST.
  localparam logic [1:0]       LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEM - 1);

  readout_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [1:0]        lat_q,   lat_d;
  logic              overrun_q, overrun_d;

  logic              load_en;
  logic              shift_en;
  logic [CNT_W-1:0]  elem_cnt;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    // DONE counts as busy, so a start landing there is also an overrun.
    overrun_d = overrun_q | (start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        lat_d   = 2'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          load_en = 1'b1;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      SEND: begin
        if (byte_ready) begin
          shift_en = 1'b1;
          if (elem_cnt == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      overrun_q <= overrun_d;
    end
  end

  byte_shift_out #(
    .WORD_W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (mem_q),
    .byte_o  (byte_data),
    .count_o (elem_cnt)
  );

  // Status/handshake outputs decode straight from the state register so an
  // asynchronous reset removes them without waiting for a clock edge.
  assign mem_addr   = addr_q;
  assign mem_rden   = (state_q == REQ);
  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign overrun    = overrun_q;
  assign byte_row   = elem_cnt[3:2];
  assign byte_col   = elem_cnt[1:0];
  assign byte_last  = byte_valid && (elem_cnt == CNT_LAST);

endmodule : matrix_readout_unit
`default_nettype wire

// File: tb/tb_matrix_readout_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_readout_unit
// Purpose : Scoreboard bench for matrix_readout_unit. Two instances: one at
//           READ_LATENCY=1, one at READ_LATENCY=3. Stimulus pushes expected
//           elements into per-instance queues; monitors pop and compare on
//           every accepted byte.
// Rev     : 1.0  initial release
// ============================================================================
module tb_matrix_readout_unit;

  typedef struct {
    logic [7:0] d;
    logic [1:0] r;
    logic [1:0] c;
    logic       l;
  } exp_t;

  logic clk;
  logic rst;

  // instance 1 (READ_LATENCY = 1)
  logic         start, mem_rden, byte_valid, byte_ready, byte_last, busy, done, overrun;
  logic [3:0]   start_addr, mem_addr;
  logic [127:0] mem_q;
  logic [7:0]   byte_data;
  logic [1:0]   byte_row, byte_col;

  // instance 3 (READ_LATENCY = 3)
  logic         start3, mem_rden3, byte_valid3, byte_ready3, byte_last3, busy3, done3, overrun3;
  logic [3:0]   start_addr3, mem_addr3;
  logic [127:0] mem_q3;
  logic [7:0]   byte_data3;
  logic [1:0]   byte_row3, byte_col3;

  int errors = 0;
  int checks = 0;
  int n_xfer1 = 0;
  int ready_mode = 0;

  exp_t q1[$];
  exp_t q3[$];

  logic [127:0] mem1 [16];
  logic [127:0] mem3 [16];
  logic [127:0] p1;
  logic [127:0] p3 [3];

  matrix_readout_unit #(.DATA_W(128), .ADDR_W(4), .READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_row(byte_row), .byte_col(byte_col), .byte_last(byte_last),
    .busy(busy), .done(done), .overrun(overrun)
  );

  matrix_readout_unit #(.DATA_W(128), .ADDR_W(4), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .start_addr(start_addr3),
    .mem_addr(mem_addr3), .mem_rden(mem_rden3), .mem_q(mem_q3),
    .byte_data(byte_data3), .byte_valid(byte_valid3), .byte_ready(byte_ready3),
    .byte_row(byte_row3), .byte_col(byte_col3), .byte_last(byte_last3),
    .busy(busy3), .done(done3), .overrun(overrun3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: registered read of the current address every edge, so a
  // later write to the same word does show up on mem_q after the latency.
  always @(posedge clk) begin
    p1    <= mem1[mem_addr];
    p3[0] <= mem3[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_q  = p1;
  assign mem_q3 = p3[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input int which, input logic [127:0] w);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.d = w[127 - 8*i -: 8];
      e.r = 2'(i / 4);
      e.c = 2'(i % 4);
      e.l = (i == 15);
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
    end
  endfunction

  // byte_ready driver: constant 1 or the 1,0,0,1 pattern
  initial begin
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      byte_ready = (ready_mode != 0) ? pat[idx] : 1'b1;
      idx = (idx + 1) % 4;
    end
  end

  // Monitor for instance 1: scoreboard plus stall stability
  initial begin
    logic       stall;
    logic [7:0] s_d;
    logic [1:0] s_r, s_c;
    exp_t       e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", {127'd0, byte_valid}, 128'd1);
          chk("stall_data", {122'd0, byte_data, byte_row, byte_col}, {122'd0, s_d, s_r, s_c});
        end
        if (byte_valid && byte_ready) begin
          if (q1.size() == 0) begin
            chk("unexpected_byte1", {120'd0, byte_data}, 128'hx_dead);
          end else begin
            e = q1.pop_front();
            chk("byte1", {115'd0, byte_data, byte_row, byte_col, byte_last},
                         {115'd0, e.d, e.r, e.c, e.l});
          end
          n_xfer1++;
        end
        stall = byte_valid && !byte_ready;
        s_d = byte_data;
        s_r = byte_row;
        s_c = byte_col;
      end
    end
  end

  // Monitor for instance 3
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && byte_valid3 && byte_ready3) begin
        if (q3.size() == 0) begin
          chk("unexpected_byte3", {120'd0, byte_data3}, 128'hx_dead);
        end else begin
          e = q3.pop_front();
          chk("byte3", {115'd0, byte_data3, byte_row3, byte_col3, byte_last3},
                       {115'd0, e.d, e.r, e.c, e.l});
        end
      end
    end
  end

  // Called at posedge+1 of cycle 0 with byte_ready held 1. Runs cycles 0..19,
  // returns at posedge+1 of cycle 20. mid (nonzero) re-pulses start in that cycle.
  task automatic run_timed(input logic [127:0] w, input logic [3:0] a, input int mid);
    push_word(1, w);
    start = 1'b1;
    start_addr = a;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("rden_c%0d", c),  {127'd0, mem_rden},   {127'd0, c == 1});
      chk($sformatf("valid_c%0d", c), {127'd0, byte_valid}, {127'd0, (c >= 3) && (c <= 18)});
      chk($sformatf("done_c%0d", c),  {127'd0, done},       {127'd0, c == 19});
      @(posedge clk);
      #1;
      start = (mid != 0) && (c + 1 == mid);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int k;
    k = 0;
    while (k < bound) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    if (k >= bound) chk(name, 128'd0, 128'd1);
  endtask

  initial begin
    int n0;
    int k;
    rst = 1'b0;
    start = 1'b0;
    start_addr = 4'd0;
    start3 = 1'b0;
    start_addr3 = 4'd0;
    byte_ready3 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 128'd0;
      mem3[i] = 128'd0;
    end
    mem1[0]  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    mem1[2]  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    mem1[7]  = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    mem1[15] = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    mem3[5]  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   {127'd0, byte_valid}, 128'd0);
    chk("rst_busy",    {127'd0, busy},       128'd0);
    chk("rst_done",    {127'd0, done},       128'd0);
    chk("rst_overrun", {127'd0, overrun},    128'd0);
    chk("rst_rden",    {127'd0, mem_rden},   128'd0);
    chk("rst_addr",    {124'd0, mem_addr},   128'd0);
    chk("rst_data",    {120'd0, byte_data},  128'd0);
    chk("rst_rowcol",  {124'd0, byte_row, byte_col}, 128'd0);
    chk("rst_last",    {127'd0, byte_last},  128'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // 1 + 6: nominal timing, order, row/col, last
    @(posedge clk);
    #1;
    run_timed(mem1[0], 4'd0, 0);
    chk("t1_q_empty", 128'(q1.size()), 128'd0);
    chk("t1_overrun", {127'd0, overrun}, 128'd0);

    // 2: byte_ready toggling 1,0,0,1
    ready_mode = 1;
    push_word(1, mem1[2]);
    start = 1'b1;
    start_addr = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t2_done_timeout", 200);
    chk("t2_q_empty", 128'(q1.size()), 128'd0);
    ready_mode = 0;
    byte_ready = 1'b1;

    // 3: start during SEND, then start one cycle after done
    @(posedge clk);
    #1;
    run_timed(mem1[7], 4'd7, 8);
    chk("t3_overrun_set", {127'd0, overrun}, 128'd1);
    run_timed(mem1[2], 4'd2, 0);
    chk("t3_overrun_sticky", {127'd0, overrun}, 128'd1);
    chk("t3_q_empty", 128'(q1.size()), 128'd0);

    // 4: asynchronous reset after the 5th transfer
    n0 = n_xfer1;
    push_word(1, mem1[15]);
    start = 1'b1;
    start_addr = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while ((n_xfer1 - n0 < 5) && (k < 40)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t4_five_xfers", 128'(n_xfer1 - n0), 128'd5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t4_async_valid", {127'd0, byte_valid}, 128'd0);
    chk("t4_async_busy",  {127'd0, busy},       128'd0);
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    chk("t4_overrun_clr", {127'd0, overrun}, 128'd0);
    // re-read from element 0; extra start lands in the DONE cycle
    run_timed(mem1[15], 4'd15, 19);
    chk("t4_done_start_overrun", {127'd0, overrun}, 128'd1);
    start = 1'b0;
    @(negedge clk);
    chk("t4_done_start_ignored_busy", {127'd0, busy},     128'd0);
    @(negedge clk);
    chk("t4_done_start_ignored_rden", {127'd0, mem_rden}, 128'd0);
    chk("t4_q_empty", 128'(q1.size()), 128'd0);

    // 5: READ_LATENCY=3, address 5, memory changes after capture
    @(posedge clk);
    #1;
    push_word(3, mem3[5]);
    start3 = 1'b1;
    start_addr3 = 4'd5;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) chk($sformatf("t5_addr_c%0d", c), {124'd0, mem_addr3}, 128'd5);
      chk($sformatf("t5_rden_c%0d", c),  {127'd0, mem_rden3},   {127'd0, c == 1});
      chk($sformatf("t5_valid_c%0d", c), {127'd0, byte_valid3}, {127'd0, c >= 5});
      @(posedge clk);
      #1;
      start3 = 1'b0;
      if (c == 4) mem3[5] = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    end
    k = 0;
    while (!done3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_done_seen", {127'd0, done3}, 128'd1);
    chk("t5_q_empty", 128'(q3.size()), 128'd0);
    chk("t5_overrun", {127'd0, overrun3}, 128'd0);
    @(negedge clk);
    chk("t5_idle", {127'd0, busy3}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_matrix_readout_unit
`default_nettype wire

// File: doc/matrix_readout_unit.md
Name: matrix_readout_unit

Overview:
Read-side counterpart of the vector core's result-matrix write path. After the pipeline commits a 128-bit result matrix into MemData (wren_a pulse), this block reads the word back through the memory's second port. It then streams it out as 16 bytes, row-major, over a valid/ready byte interface for a display or serial consumer. It sits beside MemData and observes the memory-stage write strobe, but never writes memory itself.

Parameters:
DATA_W, 128, width of one matrix word in MemData (4 rows x 4 elements x 8 bits)
ADDR_W, 4, MemData address width
READ_LATENCY, 1, cycles from mem_rden sampled to mem_q valid (1..3)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  1-cycle trigger; driven by the memory-stage memWrite strobe
start_addr  in  ADDR_W  word address to read back; sampled with start
mem_addr  out  ADDR_W  MemData port-b address
mem_rden  out  1  MemData port-b read enable, 1-cycle pulse
mem_q  in  DATA_W  MemData port-b read data
byte_data  out  8  current output element
byte_valid  out  1  byte_data is valid
byte_ready  in  1  consumer accepts byte_data when high with byte_valid
byte_row  out  2  row index of byte_data (0..3)
byte_col  out  2  column index of byte_data (0..3)
byte_last  out  1  high with byte_valid on the 16th element
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse after the last byte transfers
overrun  out  1  sticky: a start arrived while busy

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; shift register, element counter, latency counter and captured address all 0.
- FSM states:
  - IDLE: when start=1, capture start_addr and go to REQ.
  - REQ: lasts 1 cycle. mem_rden=1 and mem_addr=captured address. Go to WAIT.
  - WAIT: lasts READ_LATENCY cycles. mem_addr holds its value. On the last WAIT edge, load mem_q into the 128-bit shift register and go to SEND.
  - SEND: byte_valid=1 and byte_data=shift[127:120]. On each edge with byte_valid&&byte_ready: shift left by 8 and increment the 4-bit counter. On the transfer at count=15, go to DONE.
  - DONE: lasts 1 cycle. done=1, then go to IDLE.
- Timing: with start high in cycle 0, mem_rden is high in cycle 1 and byte_valid first rises in cycle 2+READ_LATENCY. With byte_ready held at 1, done pulses in cycle 18+READ_LATENCY. The block accepts a new start in IDLE the following cycle.
- Element order: bits [127:120] go out first (row 0, col 0), bits [7:0] last (row 3, col 3).
  - byte_row = count[3:2], byte_col = count[1:0].
  - byte_last = byte_valid && count==15.
- Handshake (AXI-stream-like):
  - Once byte_valid is asserted, byte_data, byte_row and byte_col stay stable until accepted.
  - byte_valid never drops before acceptance.
  - byte_ready may toggle freely. A stall of any length only holds the current state.
- start while busy (any non-IDLE state): ignored, and overrun is set. overrun clears only on reset.
- start in the same cycle DONE returns to IDLE: ignored and sets overrun, because DONE counts as busy.
- mem_q is sampled only on the capture edge. Memory writes to the same address after capture do not affect the bytes in flight.
- The element counter wraps 15→0 only on the final transfer, which coincides with the move to DONE.
- Reset mid-transfer: immediate return to IDLE. byte_valid and busy drop asynchronously, and the partial stream is abandoned.

Decomposition:
- Shared package (vpu_pkg): ELEM_W=8, ROWS=4, COLS=4, DATA_W and ADDR_W constants; state enum readout_state_t {IDLE, REQ, WAIT, SEND, DONE}.
- One sub-module, byte_shift_out: 128-bit load/shift register plus 4-bit element counter, with load/shift enables. The FSM stays in matrix_readout_unit.

Test Plan:
1. After reset, pulse start with start_addr=0. The memory model (READ_LATENCY=1) returns 0x00010203_04050607_08090A0B_0C0D0E0F, and byte_ready is held at 1. Required: mem_rden in cycle 1 only; bytes 0x00..0x0F in cycles 3..18; byte_last with 0x0F; done in cycle 19.
2. Same stimulus with byte_ready toggling 1,0,0,1,… Required: all 16 bytes appear once, in order; byte_data, byte_row and byte_col stay stable during each stall; no byte is dropped or duplicated.
3. Pulse start again during SEND. Required: overrun=1 and the stream is unaffected. A start 1 cycle after done begins a new read with overrun still 1.
4. Drive rst=0 asynchronously after the 5th transfer. Required: byte_valid=0 and busy=0 before the next clk edge. A subsequent start re-reads from element 0.
5. READ_LATENCY=3, start_addr=0x5, and the memory changes its word at 0x5 one cycle after capture. Required: mem_addr=0x5 throughout REQ and WAIT; first byte_valid in cycle 5; bytes come from the pre-change word.
6. Check row/col indexing. Required: byte_row:byte_col runs 0:0, 0:1, … 3:3 across the 16 transfers, and byte_last is high only on 3:3.
